// File: rtl/adc_uart_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_uart_packer                                                            |
// | Buffers 12-bit ADC samples and frames them into bytes for uart_tx.         |
// | Optional: ADC_PKT_CHECKSUM_EN appends a third checksum byte per frame.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adc_uart_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEVEL_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [11:0]        sample_in,
    input  logic               sample_valid,
    output logic [7:0]         data_to_tx,
    output logic               start_tx,
    input  logic               tx_busy,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow,
    output logic               frame_done
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LEVEL_W-1:0] c_full = LEVEL_W'(FIFO_DEPTH);
`ifdef ADC_PKT_CHECKSUM_EN
    localparam logic [1:0] c_last_idx = 2'd2;
`else
    localparam logic [1:0] c_last_idx = 2'd1;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [11:0]        r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_pend_ovf;
    logic               r_overflow;

    state_t             r_state;
    state_t             w_state_d;
    logic [7:0]         r_data;
    logic [7:0]         w_data_d;
    logic               r_start;
    logic               w_start_d;
    logic [1:0]         r_byte_idx;
    logic [1:0]         w_idx_d;
    logic               r_frame_done;
    logic               w_done_d;
    logic [7:0]         r_byte1;
    logic [7:0]         w_next_byte;

    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic [11:0]        w_head;
    logic [7:0]         w_byte0;
    logic [7:0]         w_byte1;

    // Fullness is judged before any same-cycle pop.
    assign w_full  = (r_level == c_full);
    assign w_push  = sample_valid && !w_full;
    assign w_drop  = sample_valid && w_full;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_byte0 = {1'b1, r_pend_ovf, w_head[11:6]};
    assign w_byte1 = {2'b00, w_head[5:0]};

`ifdef ADC_PKT_CHECKSUM_EN
    logic [7:0] r_byte2;
    logic [7:0] w_byte2;
    assign w_byte2     = {2'b01, w_head[11:6] ^ w_head[5:0]};
    assign w_next_byte = (r_byte_idx == 2'd0) ? r_byte1 : r_byte2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte2 <= 8'h00;
        end else if (w_pop) begin
            r_byte2 <= w_byte2;
        end
    end
`else
    assign w_next_byte = r_byte1;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_pend_ovf <= 1'b0;
            r_overflow <= 1'b0;
            r_byte1    <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_byte1  <= w_byte1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the pop cycle wins, so the flag carries to the next frame.
            if (w_drop) begin
                r_pend_ovf <= 1'b1;
                r_overflow <= 1'b1;
            end else if (w_pop) begin
                r_pend_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_data       <= 8'h00;
            r_start      <= 1'b0;
            r_byte_idx   <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_data       <= w_data_d;
            r_start      <= w_start_d;
            r_byte_idx   <= w_idx_d;
            r_frame_done <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_data_d  = r_data;
        w_start_d = r_start;
        w_idx_d   = r_byte_idx;
        w_done_d  = 1'b0;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                // Holding off while frame_done is high guarantees an idle gap.
                if ((r_level != '0) && !r_frame_done) begin
                    w_pop     = 1'b1;
                    w_data_d  = w_byte0;
                    w_start_d = 1'b1;
                    w_idx_d   = 2'd0;
                    w_state_d = SEND;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    w_start_d = 1'b0;
                    w_state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                w_state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_byte_idx == c_last_idx) begin
                        w_done_d  = 1'b1;
                        w_state_d = IDLE;
                    end else begin
                        w_idx_d   = r_byte_idx + 2'd1;
                        w_data_d  = w_next_byte;
                        w_start_d = 1'b1;
                        w_state_d = SEND;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign data_to_tx = r_data;
    assign start_tx   = r_start;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
